// File: rtl/bus_arbiter_if.sv
// Bus bundle shared by the requesting masters, the round-robin arbiter and the downstream slave.
// m_* signals are the per-master side (packed 32 bits per master), s_* the shared slave side.
interface bus_arbiter_if #(
   parameter int NUM_MASTERS = 2
);
   logic [NUM_MASTERS-1:0]    m_valid;
   logic [32*NUM_MASTERS-1:0] m_addr;
   logic [32*NUM_MASTERS-1:0] m_write_data;
   logic [NUM_MASTERS-1:0]    m_rnw;
   logic [NUM_MASTERS-1:0]    m_ready;
   logic [31:0]               m_read_data;
   logic [NUM_MASTERS-1:0]    m_error;

   logic                      s_valid;
   logic [31:0]               s_addr;
   logic [31:0]               s_write_data;
   logic                      s_rnw;
   logic                      s_ready;
   logic [31:0]               s_read_data;
   logic                      s_error;

   modport arbiter (
      input  m_valid, m_addr, m_write_data, m_rnw,
      output m_ready, m_read_data, m_error,
      output s_valid, s_addr, s_write_data, s_rnw,
      input  s_ready, s_read_data, s_error
   );

   modport master (
      output m_valid, m_addr, m_write_data, m_rnw,
      input  m_ready, m_read_data, m_error
   );

   modport slave (
      input  s_valid, s_addr, s_write_data, s_rnw,
      output s_ready, s_read_data, s_error
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between NUM_MASTERS masters, with a slave-response
// timeout that forces an error completion when the slave never answers.
module bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   bus_arbiter_if.arbiter                 bus,
   output logic                           grant_valid,
   output logic [$clog2(NUM_MASTERS)-1:0] grant_id
);
   localparam int unsigned NM  = NUM_MASTERS;
   localparam int          IDW = $clog2(NUM_MASTERS);
   localparam int          CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_MASTERS - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           any_req;
   logic           timeout_hit;
   logic [IDW-1:0] pick;

   // First requester at or above start, wrapping past the top index back to 0.
   function automatic logic [IDW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [IDW-1:0] start);
      logic [IDW-1:0] sel;
      logic           found;
      int unsigned    j;
      sel   = start;
      found = 1'b0;
      for (int unsigned k = 0; k < NM; k++) begin
         j = 32'(start) + k;
         if (j >= NM) j = j - NM;
         if (!found && req[IDW'(j)]) begin
            sel   = IDW'(j);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign any_req = |bus.m_valid;
   assign pick    = rr_pick(bus.m_valid, ptr_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      grant_d          = grant_q;
      cnt_d            = cnt_q;
      timeout_hit      = 1'b0;
      bus.s_valid      = 1'b0;
      bus.s_addr       = '0;
      bus.s_write_data = '0;
      bus.s_rnw        = 1'b0;
      bus.m_ready      = '0;
      bus.m_error      = '0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = pick;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            bus.s_valid = 1'b1;
            for (int unsigned k = 0; k < NM; k++) begin
               if (grant_q == IDW'(k)) begin
                  bus.s_addr       = bus.m_addr[32*k +: 32];
                  bus.s_write_data = bus.m_write_data[32*k +: 32];
                  bus.s_rnw        = bus.m_rnw[k];
               end
            end
            // A slave answer in the last allowed cycle wins over the forced timeout error.
            timeout_hit = (TIMEOUT > 0) && !bus.s_ready && (cnt_q == CNT_LAST);
            if (bus.s_ready || timeout_hit) begin
               bus.m_ready[grant_q] = 1'b1;
               bus.m_error[grant_q] = bus.s_ready ? bus.s_error : 1'b1;
               ptr_d   = (grant_q == ID_LAST) ? '0 : grant_q + IDW'(1);
               state_d = IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   assign grant_valid     = (state_q == BUSY);
   assign grant_id        = grant_q;
   assign bus.m_read_data = bus.s_read_data;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model (4 masters, 4-cycle timeout).
module tb_bus_arbiter;
   localparam int NM = 4;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       grant_valid;
   logic [1:0] grant_id;
   int         checks = 0;
   int         errors = 0;

   bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

   bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic clear_inputs();
      bus.m_valid      = '0;
      bus.m_addr       = '0;
      bus.m_write_data = '0;
      bus.m_rnw        = '0;
      bus.s_ready      = 1'b0;
      bus.s_error      = 1'b0;
      bus.s_read_data  = '0;
   endtask

   task automatic set_master(input int i, input logic [31:0] a, input logic [31:0] d, input logic r);
      bus.m_addr[32*i +: 32]       = a;
      bus.m_write_data[32*i +: 32] = d;
      bus.m_rnw[i]                 = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      clear_inputs();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      bus.m_valid      = '1;
      bus.m_addr       = '1;
      bus.m_write_data = '1;
      bus.m_rnw        = '1;
      bus.s_ready      = 1'b1;
      bus.s_error      = 1'b1;
      bus.s_read_data  = 32'h1234_5678;
      step();
      step();
      @(negedge clk);
      checks++;
      if (bus.s_valid !== 1'b0 || grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: s_valid=%b grant_valid=%b required 0 0", bus.s_valid, grant_valid);
      end
      checks++;
      if (bus.s_addr !== 32'h0 || bus.s_write_data !== 32'h0 || bus.s_rnw !== 1'b0) begin
         errors++;
         $display("FAIL reset_payload: addr=%h wdata=%h rnw=%b required 0 0 0", bus.s_addr, bus.s_write_data, bus.s_rnw);
      end
      checks++;
      if (bus.m_ready !== 4'b0 || bus.m_error !== 4'b0) begin
         errors++;
         $display("FAIL reset_ready: m_ready=%b m_error=%b required 0000 0000", bus.m_ready, bus.m_error);
      end
      checks++;
      if (grant_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_grant_id: got %0d required 0", grant_id);
      end
      checks++;
      if (bus.m_read_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL reset_read_data: got %h required 12345678", bus.m_read_data);
      end
   endtask

   task automatic test_single_read();
      int pulses;
      pulses = 0;
      do_reset();
      set_master(1, 32'h0000_1000, 32'h0, 1'b1);
      bus.m_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (bus.s_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_latency_pre: s_valid=%b required 0", bus.s_valid);
      end
      for (int c = 1; c <= 4; c++) begin
         step();
         bus.s_ready     = (c == 3);
         bus.s_read_data = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
         if (c == 4) bus.m_valid = '0;
         @(negedge clk);
         if (bus.m_ready[1] === 1'b1) pulses++;
         if (c <= 3) begin
            checks++;
            if (bus.s_valid !== 1'b1 || grant_id !== 2'd1 || bus.s_addr !== 32'h1000 || bus.s_rnw !== 1'b1) begin
               errors++;
               $display("FAIL read_busy c%0d: s_valid=%b id=%0d addr=%h rnw=%b required 1 1 00001000 1",
                        c, bus.s_valid, grant_id, bus.s_addr, bus.s_rnw);
            end
         end
         if (c < 3) begin
            checks++;
            if (bus.m_ready !== 4'b0) begin
               errors++;
               $display("FAIL read_early_ready c%0d: m_ready=%b required 0000", c, bus.m_ready);
            end
         end
         if (c == 3) begin
            checks++;
            if (bus.m_ready !== 4'b0010 || bus.m_error !== 4'b0 || bus.m_read_data !== 32'hDEAD_BEEF) begin
               errors++;
               $display("FAIL read_done: m_ready=%b m_error=%b rdata=%h required 0010 0000 deadbeef",
                        bus.m_ready, bus.m_error, bus.m_read_data);
            end
         end
         if (c == 4) begin
            checks++;
            if (bus.s_valid !== 1'b0 || grant_valid !== 1'b0) begin
               errors++;
               $display("FAIL read_release: s_valid=%b grant_valid=%b required 0 0", bus.s_valid, grant_valid);
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL read_pulse_count: got %0d required 1", pulses);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_id;
      logic [3:0] exp_rdy;
      do_reset();
      for (int i = 0; i < NM; i++) set_master(i, 32'h100 + 32'(i), 32'hA0 + 32'(i), 1'b0);
      bus.m_valid = '1;
      bus.s_ready = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         @(negedge clk);
         exp_id  = 2'(((c - 1) / 2) % 4);
         exp_rdy = '0;
         exp_rdy[exp_id] = 1'b1;
         checks++;
         if (c % 2 == 1) begin
            if (grant_valid !== 1'b1 || grant_id !== exp_id || bus.m_ready !== exp_rdy ||
                bus.s_addr !== 32'h100 + 32'(exp_id)) begin
               errors++;
               $display("FAIL fair_grant c%0d: gv=%b id=%0d m_ready=%b addr=%h required 1 %0d %b %h",
                        c, grant_valid, grant_id, bus.m_ready, bus.s_addr, exp_id, exp_rdy, 32'h100 + 32'(exp_id));
            end
         end else begin
            if (grant_valid !== 1'b0 || bus.m_ready !== 4'b0) begin
               errors++;
               $display("FAIL fair_gap c%0d: gv=%b m_ready=%b required 0 0000", c, grant_valid, bus.m_ready);
            end
         end
      end
   endtask

   task automatic test_error();
      do_reset();
      set_master(0, 32'h20, 32'h55AA_55AA, 1'b0);
      bus.m_valid = 4'b0001;
      for (int c = 1; c <= 3; c++) begin
         step();
         bus.s_ready = (c == 2);
         bus.s_error = (c == 2);
         if (c == 3) bus.m_valid = '0;
         @(negedge clk);
         if (c <= 2) begin
            checks++;
            if (bus.s_valid !== 1'b1 || bus.s_addr !== 32'h20 || bus.s_write_data !== 32'h55AA_55AA || bus.s_rnw !== 1'b0) begin
               errors++;
               $display("FAIL err_payload c%0d: s_valid=%b addr=%h wdata=%h rnw=%b required 1 00000020 55aa55aa 0",
                        c, bus.s_valid, bus.s_addr, bus.s_write_data, bus.s_rnw);
            end
         end
         checks++;
         if (c == 2) begin
            if (bus.m_ready !== 4'b0001 || bus.m_error !== 4'b0001) begin
               errors++;
               $display("FAIL err_passthrough: m_ready=%b m_error=%b required 0001 0001", bus.m_ready, bus.m_error);
            end
         end else if (bus.m_ready !== 4'b0 || bus.m_error !== 4'b0) begin
            errors++;
            $display("FAIL err_quiet c%0d: m_ready=%b m_error=%b required 0000 0000", c, bus.m_ready, bus.m_error);
         end
      end
   endtask

   task automatic test_timeout();
      // Slave never answers: forced error completion in BUSY cycle 4, then ptr moves past master 2.
      do_reset();
      set_master(2, 32'h300, 32'h0, 1'b1);
      set_master(3, 32'h400, 32'h0, 1'b1);
      bus.m_valid = 4'b0100;
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 5) bus.m_valid = 4'b1100;
         bus.s_ready = (c == 6);
         if (c == 7) bus.m_valid = '0;
         @(negedge clk);
         checks++;
         if (c < 4) begin
            if (bus.s_valid !== 1'b1 || bus.m_ready !== 4'b0 || bus.m_error !== 4'b0) begin
               errors++;
               $display("FAIL to_wait c%0d: s_valid=%b m_ready=%b m_error=%b required 1 0000 0000",
                        c, bus.s_valid, bus.m_ready, bus.m_error);
            end
         end else if (c == 4) begin
            if (bus.s_valid !== 1'b1 || bus.m_ready !== 4'b0100 || bus.m_error !== 4'b0100) begin
               errors++;
               $display("FAIL to_fire: s_valid=%b m_ready=%b m_error=%b required 1 0100 0100",
                        bus.s_valid, bus.m_ready, bus.m_error);
            end
         end else if (c == 5) begin
            if (bus.s_valid !== 1'b0 || grant_valid !== 1'b0 || bus.m_ready !== 4'b0) begin
               errors++;
               $display("FAIL to_release: s_valid=%b gv=%b m_ready=%b required 0 0 0000",
                        bus.s_valid, grant_valid, bus.m_ready);
            end
         end else if (c == 6) begin
            if (grant_valid !== 1'b1 || grant_id !== 2'd3 || bus.m_ready !== 4'b1000 || bus.m_error !== 4'b0) begin
               errors++;
               $display("FAIL to_ptr_advance: gv=%b id=%0d m_ready=%b m_error=%b required 1 3 1000 0000",
                        grant_valid, grant_id, bus.m_ready, bus.m_error);
            end
         end else begin
            if (grant_valid !== 1'b0) begin
               errors++;
               $display("FAIL to_idle: gv=%b required 0", grant_valid);
            end
         end
      end

      // Slave answers in the final allowed cycle: normal completion without error.
      do_reset();
      set_master(1, 32'h200, 32'h0, 1'b1);
      bus.m_valid = 4'b0010;
      for (int c = 1; c <= 5; c++) begin
         step();
         bus.s_ready = (c == 4);
         bus.s_error = 1'b0;
         if (c == 5) bus.m_valid = '0;
         @(negedge clk);
         checks++;
         if (c < 4) begin
            if (bus.m_ready !== 4'b0 || bus.s_valid !== 1'b1) begin
               errors++;
               $display("FAIL to_late_wait c%0d: m_ready=%b s_valid=%b required 0000 1", c, bus.m_ready, bus.s_valid);
            end
         end else if (c == 4) begin
            if (bus.m_ready !== 4'b0010 || bus.m_error !== 4'b0) begin
               errors++;
               $display("FAIL to_late_ready: m_ready=%b m_error=%b required 0010 0000", bus.m_ready, bus.m_error);
            end
         end else begin
            if (bus.s_valid !== 1'b0 || bus.m_ready !== 4'b0) begin
               errors++;
               $display("FAIL to_late_release: s_valid=%b m_ready=%b required 0 0000", bus.s_valid, bus.m_ready);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_master(1, 32'h111, 32'h0, 1'b0);
      set_master(2, 32'h222, 32'h0, 1'b0);
      bus.m_valid = 4'b0100;
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c == 2) reset = 1'b1;
         if (c == 3) begin
            reset       = 1'b0;
            bus.m_valid = 4'b0110;
            bus.s_ready = 1'b1;
         end
         if (c == 5) begin
            bus.m_valid = '0;
            bus.s_ready = 1'b0;
         end
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
               errors++;
               $display("FAIL rst_mid_grant: gv=%b id=%0d required 1 2", grant_valid, grant_id);
            end
         end
         if (c == 3) begin
            checks++;
            if (bus.s_valid !== 1'b0 || grant_valid !== 1'b0 || bus.m_ready !== 4'b0 || grant_id !== 2'd0) begin
               errors++;
               $display("FAIL rst_mid_abort: s_valid=%b gv=%b m_ready=%b id=%0d required 0 0 0000 0",
                        bus.s_valid, grant_valid, bus.m_ready, grant_id);
            end
         end
         if (c == 4) begin
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== 2'd1 || bus.m_ready !== 4'b0010) begin
               errors++;
               $display("FAIL rst_mid_regrant: gv=%b id=%0d m_ready=%b required 1 1 0010",
                        grant_valid, grant_id, bus.m_ready);
            end
         end
      end
   endtask

   task automatic test_requester_order();
      do_reset();
      for (int i = 0; i < 3; i++) set_master(i, 32'h40 + 32'(i), 32'h0, 1'b1);
      bus.m_valid = 4'b0100;
      bus.s_ready = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 1) bus.m_valid = 4'b0111;
         if (c == 2) bus.m_valid = 4'b0011;
         if (c == 4) bus.m_valid = 4'b0010;
         if (c == 6) bus.m_valid = '0;
         @(negedge clk);
         checks++;
         if (c == 1) begin
            if (grant_valid !== 1'b1 || grant_id !== 2'd2 || bus.m_ready !== 4'b0100) begin
               errors++;
               $display("FAIL order_first: gv=%b id=%0d m_ready=%b required 1 2 0100", grant_valid, grant_id, bus.m_ready);
            end
         end else if (c == 3) begin
            if (grant_valid !== 1'b1 || grant_id !== 2'd0 || bus.m_ready !== 4'b0001) begin
               errors++;
               $display("FAIL order_wrap: gv=%b id=%0d m_ready=%b required 1 0 0001", grant_valid, grant_id, bus.m_ready);
            end
         end else if (c == 5) begin
            if (grant_valid !== 1'b1 || grant_id !== 2'd1 || bus.m_ready !== 4'b0010) begin
               errors++;
               $display("FAIL order_next: gv=%b id=%0d m_ready=%b required 1 1 0010", grant_valid, grant_id, bus.m_ready);
            end
         end else if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_gap c%0d: gv=%b required 0", c, grant_valid);
         end
      end
   endtask

   task automatic test_random();
      // Model tracks "who owns the bus and for how many cycles", not the arbiter's registers.
      bit          busy;
      int unsigned owner, next_start, cycles_waited;
      bit          found, fin;
      bit [NM-1:0] pend, exp_rdy, exp_err;
      logic [31:0] a [NM];
      logic [31:0] d [NM];
      logic        r [NM];
      logic [31:0] exp_addr, exp_wdata;
      logic        exp_rnw;
      do_reset();
      busy = 1'b0; owner = 0; next_start = 0; cycles_waited = 0;
      pend = '0; exp_rdy = '0;
      for (int i = 0; i < NM; i++) begin
         a[i] = '0; d[i] = '0; r[i] = 1'b0;
      end
      for (int n = 0; n < 600; n++) begin
         step();
         if (!busy) begin
            found = 1'b0;
            for (int k = 0; k < NM; k++) begin
               if (!found && bus.m_valid[(next_start + k) % NM]) begin
                  owner = (next_start + k) % NM;
                  found = 1'b1;
               end
            end
            if (found) begin
               busy = 1'b1;
               cycles_waited = 0;
            end
         end else if (bus.s_ready || (TO > 0 && cycles_waited + 1 == TO)) begin
            next_start = (owner + 1) % NM;
            busy = 1'b0;
         end else begin
            cycles_waited++;
         end

         for (int i = 0; i < NM; i++) begin
            if (exp_rdy[i]) pend[i] = 1'b0;
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               a[i] = $urandom;
               d[i] = $urandom;
               r[i] = 1'($urandom_range(0, 1));
               set_master(i, a[i], d[i], r[i]);
            end
         end
         bus.m_valid     = pend;
         bus.s_ready     = ($urandom_range(0, 3) == 0);
         bus.s_error     = 1'($urandom_range(0, 1));
         bus.s_read_data = $urandom;
         @(negedge clk);

         fin     = busy && (bus.s_ready || (TO > 0 && cycles_waited + 1 == TO));
         exp_rdy = '0;
         exp_err = '0;
         if (fin) begin
            exp_rdy[owner] = 1'b1;
            exp_err[owner] = !bus.s_ready || bus.s_error;
         end
         exp_addr  = busy ? a[owner] : 32'h0;
         exp_wdata = busy ? d[owner] : 32'h0;
         exp_rnw   = busy ? r[owner] : 1'b0;

         checks++;
         if (grant_valid !== busy || grant_id !== 2'(owner)) begin
            errors++;
            $display("FAIL rand_grant n%0d: gv=%b id=%0d required %b %0d", n, grant_valid, grant_id, busy, owner);
         end
         checks++;
         if (bus.s_valid !== busy || bus.s_addr !== exp_addr || bus.s_write_data !== exp_wdata || bus.s_rnw !== exp_rnw) begin
            errors++;
            $display("FAIL rand_slave n%0d: s_valid=%b addr=%h wdata=%h rnw=%b required %b %h %h %b",
                     n, bus.s_valid, bus.s_addr, bus.s_write_data, bus.s_rnw, busy, exp_addr, exp_wdata, exp_rnw);
         end
         checks++;
         if (bus.m_ready !== exp_rdy || bus.m_error !== exp_err) begin
            errors++;
            $display("FAIL rand_resp n%0d: m_ready=%b m_error=%b required %b %b", n, bus.m_ready, bus.m_error, exp_rdy, exp_err);
         end
         checks++;
         if (bus.m_read_data !== bus.s_read_data) begin
            errors++;
            $display("FAIL rand_rdata n%0d: m_read_data=%h required %h", n, bus.m_read_data, bus.s_read_data);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_fairness();
      test_error();
      test_timeout();
      test_reset_mid();
      test_requester_order();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one downstream slave bus between NUM_MASTERS requesting masters. Each master port and the slave port use the team's standard bus handshake: addr, write_data, rnw, valid, ready, read_data and error. The arbiter sits between the CPU/DMA-side masters and the shared peripheral bus. It also enforces a slave-response timeout, so a hung slave cannot stall the system.

## Interface
- NUM_MASTERS, 2: number of master ports, legal range 2..8.
- TIMEOUT, 255: cycles in BUSY without slave ready before a forced error completion; 0 disables the timeout.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset (the one clock; reset polarity and synchronicity are fixed).
- m_valid  in  NUM_MASTERS  per-master request valid.
- m_addr  in  32*NUM_MASTERS  per-master address; master i uses bits [32i+31:32i].
- m_write_data  in  32*NUM_MASTERS  per-master write data, same packing as m_addr.
- m_rnw  in  NUM_MASTERS  per-master direction: 1 = read, 0 = write.
- m_ready  out  NUM_MASTERS  per-master completion strobe.
- m_read_data  out  32  read data broadcast to all masters; valid only with that master's m_ready.
- m_error  out  NUM_MASTERS  per-master error, qualified by m_ready.
- s_valid  out  1  slave request valid.
- s_addr, s_write_data  out  32 each  slave address and write data.
- s_rnw  out  1  slave direction.
- s_ready  in  1  slave completion.
- s_read_data  in  32  slave read data.
- s_error  in  1  slave error, qualified by s_ready.
- grant_valid  out  1  high while in BUSY.
- grant_id  out  clog2(NUM_MASTERS)  index of the master currently granted.

## Operation
- Two-state FSM: IDLE and BUSY. Registered state: ptr (round-robin start index), grant_id, and a timeout counter.
- IDLE:
  - s_valid = 0; s_addr, s_write_data and s_rnw are driven to 0.
  - If any m_valid bit is set, select the first set bit searching upward from ptr with wrap at NUM_MASTERS-1 → 0.
  - Register the selected index into grant_id, clear the counter, and go to BUSY.
- BUSY:
  - s_valid = 1; s_addr, s_write_data and s_rnw are muxed from master grant_id.
  - m_ready[grant_id] = s_ready and m_error[grant_id] = s_ready & s_error.
  - All other m_ready and m_error bits are 0.
- Normal completion: on s_ready = 1, set ptr ← (grant_id+1) mod NUM_MASTERS and go to IDLE.
- Timeout (TIMEOUT > 0):
  - The counter increments each BUSY cycle without s_ready.
  - On the cycle where counter == TIMEOUT-1 and s_ready = 0, assert m_ready[grant_id] = 1 and m_error[grant_id] = 1.
  - On that cycle, advance ptr as for normal completion and go to IDLE.
  - s_valid drops the next cycle. The slave must tolerate this withdrawal.
- s_ready has priority over timeout in the same cycle: the transfer completes normally and s_error is passed through.
- m_read_data = s_read_data combinationally at all times.
- Masters must hold valid and their payload stable until ready. The arbiter does not recheck m_valid[grant_id] in BUSY; a master withdrawing its request mid-grant is a protocol violation and the transfer still completes.
- s_ready seen in IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, grant_id = 0, counter = 0.
  - s_valid = 0, s_addr = 0, s_write_data = 0, s_rnw = 0.
  - m_ready = 0, m_error = 0, grant_valid = 0.
  - m_read_data follows s_read_data.
- Reset asserted mid-BUSY forces all of the above on the next edge. No m_ready is issued for the aborted transfer.
- Grant latency:
  - m_valid sampled in IDLE at cycle N gives s_valid = 1 at cycle N+1.
  - If s_ready = 1 at cycle N+1, m_ready is high at cycle N+1 (combinational from s_ready).
  - The FSM is back in IDLE at N+2; the earliest next grant is s_valid at N+3.
  - Peak throughput is one transfer per 2 cycles.
- Timeout: with continuous s_ready = 0, the forced m_ready/m_error appears in BUSY cycle TIMEOUT (counting the first BUSY cycle as 1).
- The counter is clog2(TIMEOUT+1) bits wide, saturates, and never wraps.

## Test plan
- Single master read: master 1 requests addr 0x1000, rnw = 1; slave returns 0xDEADBEEF with ready after 3 cycles → m_ready[1] pulses once and m_read_data = 0xDEADBEEF. Measure s_valid 1 cycle after m_valid.
- Contention and fairness, NUM_MASTERS = 4: all masters request continuously; slave ready on the first cycle → grants 0,1,2,3,0. The pointer wraps 3→0, and each grant is exactly 2 cycles apart.
- Error passthrough: master 0 writes 0x55AA55AA to 0x20; slave returns ready and error together → m_ready[0] = 1 and m_error[0] = 1; s_write_data = 0x55AA55AA throughout BUSY.
- Timeout, TIMEOUT = 4: slave never readies → m_ready and m_error pulse in BUSY cycle 4, s_valid low the next cycle, and ptr advances. Second case: s_ready arrives in cycle 4 with s_error = 0 → normal completion with m_error = 0.
- Reset mid-transfer: assert reset during BUSY with master 2 granted → the next cycle shows s_valid = 0, grant_valid = 0, m_ready = 0. A request afterwards from masters 1 and 2 is granted to 1 (ptr = 0).
- Requester order: master 0 requests just as master 2 completes (ptr = 3 mod 4 → 3) with only masters 0 and 1 requesting → master 0 is granted, then master 1.
